// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer for the EX stage: multi-cycle multiply, restoring divide and MTHI/MTLO writes.
// Optional `define MULDIV_ASCII_EN adds an op_ascii debug output naming the operation in flight.
module muldiv_ctrl #(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [5:0]  req_funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
`ifdef MULDIV_ASCII_EN
    ,
    output logic [47:0] op_ascii
`endif
);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] MUL_CNT = 6'(MUL_LAT);
    localparam logic [5:0] DIV_CNT = 6'(DIV_ITER);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg;
    logic [31:0] a_reg, b_reg, hi_reg, lo_reg, rem_reg, quo_reg;
    logic        div_reg, sgn_reg, dz_reg;

    logic        is_mul, is_div, is_sgn, accept, mt_hi, mt_lo, ge;
    logic [31:0] abs_rs, dvs, quo_fix, rem_fix;
    logic [32:0] shifted, diff;
    logic [63:0] mul_a, mul_b, prod;

    assign is_mul = (req_funct == F_MULT) || (req_funct == F_MULTU);
    assign is_div = (req_funct == F_DIV) || (req_funct == F_DIVU);
    assign is_sgn = (req_funct == F_MULT) || (req_funct == F_DIV);
    assign accept = (state_reg == IDLE) && req_valid && !flush && (is_mul || is_div);
    assign mt_hi  = (state_reg == IDLE) && req_valid && !flush && (req_funct == F_MTHI);
    assign mt_lo  = (state_reg == IDLE) && req_valid && !flush && (req_funct == F_MTLO);

    // Divider works on magnitudes; signs are restored only when the result is written.
    assign abs_rs  = (is_sgn && rs_val[31]) ? -rs_val : rs_val;
    assign dvs     = (sgn_reg && b_reg[31]) ? -b_reg : b_reg;
    assign shifted = {rem_reg, quo_reg[31]};
    assign diff    = shifted - {1'b0, dvs};
    assign ge      = !diff[32];
    assign quo_fix = (sgn_reg && (a_reg[31] ^ b_reg[31])) ? -quo_reg : quo_reg;
    assign rem_fix = (sgn_reg && a_reg[31]) ? -rem_reg : rem_reg;

    assign mul_a = {{32{sgn_reg & a_reg[31]}}, a_reg};
    assign mul_b = {{32{sgn_reg & b_reg[31]}}, b_reg};
    assign prod  = mul_a * mul_b;

    always_comb begin
        state_next = state_reg;
        stall_req  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    stall_req  = 1'b1;
                    state_next = (is_div && rt_val == 32'd0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                if (flush)
                    state_next = IDLE;
                else if (cnt_reg == 6'd1)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            div_reg   <= 1'b0;
            sgn_reg   <= 1'b0;
            dz_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg   <= rs_val;
                        b_reg   <= rt_val;
                        div_reg <= is_div;
                        sgn_reg <= is_sgn;
                        dz_reg  <= is_div && (rt_val == 32'd0);
                        cnt_reg <= is_div ? DIV_CNT : MUL_CNT;
                        rem_reg <= '0;
                        quo_reg <= abs_rs;
                    end
                    if (mt_hi) hi_reg <= rs_val;
                    if (mt_lo) lo_reg <= rs_val;
                end
                BUSY: begin
                    cnt_reg <= cnt_reg - 6'd1;
                    if (div_reg) begin
                        rem_reg <= ge ? diff[31:0] : shifted[31:0];
                        quo_reg <= {quo_reg[30:0], ge};
                    end
                end
                DONE: begin
                    if (!flush && !dz_reg) begin
                        if (div_reg) begin
                            hi_reg <= rem_fix;
                            lo_reg <= quo_fix;
                        end else begin
                            hi_reg <= prod[63:32];
                            lo_reg <= prod[31:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign div_zero = (state_reg == DONE) && dz_reg && !flush;

`ifdef MULDIV_ASCII_EN
    always_comb begin
        op_ascii = {16'h0, "IDLE"};
        if (state_reg == BUSY || state_reg == DONE) begin
            case ({div_reg, sgn_reg})
                2'b01:   op_ascii = {16'h0, "MULT"};
                2'b00:   op_ascii = {8'h0, "MULTU"};
                2'b11:   op_ascii = {24'h0, "DIV"};
                default: op_ascii = {16'h0, "DIVU"};
            endcase
        end else if (mt_hi) begin
            op_ascii = {16'h0, "MTHI"};
        end else if (mt_lo) begin
            op_ascii = {16'h0, "MTLO"};
        end
    end
`endif

endmodule
